// File: rtl/n_bit_square_pkg.sv
// -----------------------------------------------------------------------------
// n_bit_square_pkg
// Shared constants and a reference squaring function for the pipelined
// unsigned squarer.
//   LATENCY : clock edges from operand presentation to result
//   N_DEF   : default operand width
//   sq_ref  : x*x at full 2*N_DEF precision (golden value for scoreboards)
// -----------------------------------------------------------------------------
package n_bit_square_pkg;

  localparam int LATENCY = 2;
  localparam int N_DEF   = 8;

  // Full-precision square of an N_DEF-bit operand.
  function automatic logic [2*N_DEF-1:0] sq_ref(input logic [N_DEF-1:0] x);
    logic [2*N_DEF-1:0] w_x;
    w_x = {{N_DEF{1'b0}}, x};
    return w_x * w_x;
  endfunction

endpackage

// File: rtl/n_bit_square_if.sv
// -----------------------------------------------------------------------------
// n_bit_square_if
// Operand/result bundle of the squarer.
//   num       : unsigned operand (master -> slave)
//   in_valid  : num qualifier     (master -> slave)
//   result    : square, 2N bits   (slave -> master)
//   out_valid : result qualifier  (slave -> master)
// With N_BIT_SQUARE_ACC_EN defined the bundle also carries:
//   acc_clr   : clear the running sum (master -> slave)
//   acc       : running sum of squares, 2N+8 bits (slave -> master)
// -----------------------------------------------------------------------------
interface n_bit_square_if
  import n_bit_square_pkg::*;
#(
  parameter int N = N_DEF
);

  logic [N-1:0]   num;
  logic           in_valid;
  logic [2*N-1:0] result;
  logic           out_valid;
`ifdef N_BIT_SQUARE_ACC_EN
  logic           acc_clr;
  logic [2*N+7:0] acc;

  modport master (output num, output in_valid, output acc_clr,
                  input  result, input out_valid, input acc);
  modport slave  (input  num, input in_valid, input acc_clr,
                  output result, output out_valid, output acc);
`else
  modport master (output num, output in_valid,
                  input  result, input out_valid);
  modport slave  (input  num, input in_valid,
                  output result, output out_valid);
`endif

endinterface

// File: rtl/n_bit_square_chk.sv
// -----------------------------------------------------------------------------
// n_bit_square_chk
// Run-time sanity checks for the squarer datapath.
//   clk, rst  : clock and synchronous active-high reset
//   i_carry   : top bit of the 2N+1 bit internal sum; a square of an N-bit
//               value always fits in 2N bits, so this bit must stay clear
// -----------------------------------------------------------------------------
module n_bit_square_chk (
  input logic clk,
  input logic rst,
  input logic i_carry
);

  // The internal sum must never carry past 2N bits outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (i_carry == 1'b0);
    end
  end

endmodule

// File: rtl/n_bit_square_pp.sv
// -----------------------------------------------------------------------------
// n_bit_square_pp
// Combinational H x H unsigned partial-product generator.
//   i_a, i_b : H-bit unsigned factors
//   o_p      : 2H-bit full product
// -----------------------------------------------------------------------------
module n_bit_square_pp #(
  parameter int H = 4
) (
  input  logic [H-1:0]   i_a,
  input  logic [H-1:0]   i_b,
  output logic [2*H-1:0] o_p
);

  logic [2*H-1:0] w_a;
  logic [2*H-1:0] w_b;

  // Widen both factors so the multiply is evaluated at full product width.
  always_comb begin
    w_a = {{H{1'b0}}, i_a};
    w_b = {{H{1'b0}}, i_b};
    o_p = w_a * w_b;
  end

endmodule

// File: rtl/n_bit_square.sv
// -----------------------------------------------------------------------------
// n_bit_square
// Two-stage pipelined unsigned squarer: result = num * num at 2N bits.
// Stage 1 registers the three half-width partial products hi*hi, hi*lo and
// lo*lo; stage 2 registers their weighted sum. One operand per cycle, fixed
// latency of two edges, valid bit carried alongside the data.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : n_bit_square_if.slave (num, in_valid, result, out_valid)
// Optional build macro N_BIT_SQUARE_ACC_EN adds a running sum of squares
// (bus.acc, 2N+8 bits, wraps) cleared by bus.acc_clr or rst.
// -----------------------------------------------------------------------------
module n_bit_square
  import n_bit_square_pkg::*;
#(
  parameter int N = N_DEF
) (
  input logic            clk,
  input logic            rst,
  n_bit_square_if.slave  bus
);

  localparam int H = N / 2;

  logic [H-1:0]   w_hi;
  logic [H-1:0]   w_lo;
  logic [N-1:0]   w_pp_hh;
  logic [N-1:0]   w_pp_hl;
  logic [N-1:0]   w_pp_ll;

  logic [N-1:0]   r_pp_hh;
  logic [N-1:0]   r_pp_hl;
  logic [N-1:0]   r_pp_ll;
  logic           r_v1;

  logic [2*N:0]   w_sum;
  logic [2*N-1:0] w_result_next;
  logic [2*N-1:0] r_result;
  logic           r_out_valid;

  assign w_hi = bus.num[N-1:H];
  assign w_lo = bus.num[H-1:0];

  n_bit_square_pp #(.H(H)) u_pp_hh (.i_a(w_hi), .i_b(w_hi), .o_p(w_pp_hh));
  n_bit_square_pp #(.H(H)) u_pp_hl (.i_a(w_hi), .i_b(w_lo), .o_p(w_pp_hl));
  n_bit_square_pp #(.H(H)) u_pp_ll (.i_a(w_lo), .i_b(w_lo), .o_p(w_pp_ll));

  // Stage 1: data registers load every cycle; only r_v1 carries qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pp_hh <= {N{1'b0}};
      r_pp_hl <= {N{1'b0}};
      r_pp_ll <= {N{1'b0}};
      r_v1    <= 1'b0;
    end else begin
      r_pp_hh <= w_pp_hh;
      r_pp_hl <= w_pp_hl;
      r_pp_ll <= w_pp_ll;
      r_v1    <= bus.in_valid;
    end
  end

  // num^2 = hh*2^N + 2*hl*2^H + ll; the cross term appears twice, hence H+1.
  always_comb begin
    w_sum = ({{(N+1){1'b0}}, r_pp_hh} << N)
          + ({{(N+1){1'b0}}, r_pp_hl} << (H+1))
          +  {{(N+1){1'b0}}, r_pp_ll};
    w_result_next = w_sum[2*N-1:0];
  end

  // Stage 2: register the full-precision square and its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= {(2*N){1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_result    <= w_result_next;
      r_out_valid <= r_v1;
    end
  end

  assign bus.result    = r_result;
  assign bus.out_valid = r_out_valid;

  n_bit_square_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_carry (w_sum[2*N])
  );

`ifdef N_BIT_SQUARE_ACC_EN
  logic [2*N+7:0] r_acc;
  logic [2*N+7:0] w_sq_ext;

  assign w_sq_ext = {8'b0, w_result_next};

  // Running sum of squares; a clear coinciding with a valid result restarts
  // the sum at that result rather than dropping it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= {(2*N+8){1'b0}};
    end else if (bus.acc_clr) begin
      r_acc <= r_v1 ? w_sq_ext : {(2*N+8){1'b0}};
    end else if (r_v1) begin
      r_acc <= r_acc + w_sq_ext;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign bus.acc = r_acc;
`endif

endmodule

// File: tb/tb_n_bit_square.sv
// -----------------------------------------------------------------------------
// tb_n_bit_square
// Directed self-checking bench for n_bit_square (N = 8). Expected results are
// hand-computed constants; the exhaustive sweep uses sq_ref from the package.
// Accumulator vectors are included when N_BIT_SQUARE_ACC_EN is defined.
// -----------------------------------------------------------------------------
module tb_n_bit_square;
  import n_bit_square_pkg::*;

  localparam int N = N_DEF;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  n_bit_square_if #(.N(N)) bus_if ();

  n_bit_square #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, then check the outputs.
  task automatic cyc(input logic r, input logic [N-1:0] d, input logic v,
                     input logic ev, input logic [2*N-1:0] er, input string tag);
    rst             = r;
    bus_if.num      = d;
    bus_if.in_valid = v;
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, 64'(bus_if.out_valid), 64'(ev));
    if (ev) begin
      chk({tag, ".res"}, 64'(bus_if.result), 64'(er));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] d;
    n_chk           = 0;
    n_pass          = 0;
    rst             = 1'b1;
    bus_if.num      = {N{1'b0}};
    bus_if.in_valid = 1'b0;
`ifdef N_BIT_SQUARE_ACC_EN
    bus_if.acc_clr  = 1'b0;
`endif

    // Reset with a valid operand presented: outputs stay cleared.
    cyc(1'b1, 8'd5, 1'b1, 1'b0, 16'd0, "rst0");
    chk("rst0.res0", 64'(bus_if.result), 64'd0);
    cyc(1'b1, 8'd5, 1'b1, 1'b0, 16'd0, "rst1");
    chk("rst1.res0", 64'(bus_if.result), 64'd0);
    cyc(1'b0, 8'd5, 1'b1, 1'b0, 16'd0, "post");
    chk("post.res0", 64'(bus_if.result), 64'd0);

    // Ramp, extremes and gaps; each result shows one call after its operand.
    cyc(1'b0, 8'd0,   1'b1, 1'b1, 16'd25,    "r0");
    cyc(1'b0, 8'd2,   1'b1, 1'b1, 16'd0,     "r2");
    cyc(1'b0, 8'd4,   1'b1, 1'b1, 16'd4,     "r4");
    cyc(1'b0, 8'd6,   1'b1, 1'b1, 16'd16,    "r6");
    cyc(1'b0, 8'd8,   1'b1, 1'b1, 16'd36,    "r8");
    cyc(1'b0, 8'd10,  1'b1, 1'b1, 16'd64,    "r10");
    cyc(1'b0, 8'd255, 1'b1, 1'b1, 16'd100,   "x255");
    cyc(1'b0, 8'd1,   1'b1, 1'b1, 16'd65025, "x1");
    cyc(1'b0, 8'd128, 1'b1, 1'b1, 16'd1,     "x128");
    cyc(1'b0, 8'd3,   1'b1, 1'b1, 16'd16384, "g3");
    cyc(1'b0, 8'd7,   1'b0, 1'b1, 16'd9,     "g7");
    cyc(1'b0, 8'd9,   1'b1, 1'b0, 16'd0,     "g9");
    cyc(1'b0, 8'd0,   1'b0, 1'b1, 16'd81,    "gend");

    // Reset with 10 in stage 1 and 11 at the input: both are discarded.
    cyc(1'b0, 8'd10, 1'b1, 1'b0, 16'd0, "m10");
    cyc(1'b1, 8'd11, 1'b1, 1'b0, 16'd0, "mrst");
    chk("mrst.res0", 64'(bus_if.result), 64'd0);
    cyc(1'b0, 8'd0,  1'b0, 1'b0, 16'd0,   "m1");
    cyc(1'b0, 8'd0,  1'b0, 1'b0, 16'd0,   "m2");
    cyc(1'b0, 8'd12, 1'b1, 1'b0, 16'd0,   "m12");
    cyc(1'b0, 8'd0,  1'b0, 1'b1, 16'd144, "mres");
    cyc(1'b0, 8'd0,  1'b0, 1'b0, 16'd0,   "idle");

    // Exhaustive back-to-back sweep, then drain the pipeline.
    for (int i = 0; i < 256 + LATENCY - 1; i++) begin
      d = N'(i);
      cyc(1'b0, (i < 256) ? d : {N{1'b0}}, (i < 256) ? 1'b1 : 1'b0,
          (i >= 1) ? 1'b1 : 1'b0, sq_ref(N'(i - 1)), "sweep");
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 16'd0, "drain");

`ifdef N_BIT_SQUARE_ACC_EN
    // Accumulator: 4, 20, 56, then clear; clear coinciding with a result.
    cyc(1'b1, 8'd0, 1'b0, 1'b0, 16'd0, "arst");
    chk("arst.acc", 64'(bus_if.acc), 64'd0);
    cyc(1'b0, 8'd2, 1'b1, 1'b0, 16'd0,  "a2");
    cyc(1'b0, 8'd4, 1'b1, 1'b1, 16'd4,  "a4");
    chk("a4.acc", 64'(bus_if.acc), 64'd4);
    cyc(1'b0, 8'd6, 1'b1, 1'b1, 16'd16, "a6");
    chk("a6.acc", 64'(bus_if.acc), 64'd20);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 16'd36, "a0");
    chk("a0.acc", 64'(bus_if.acc), 64'd56);
    bus_if.acc_clr = 1'b1;
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 16'd0, "aclr");
    chk("aclr.acc", 64'(bus_if.acc), 64'd0);
    bus_if.acc_clr = 1'b0;
    cyc(1'b0, 8'd3, 1'b1, 1'b0, 16'd0, "a3");
    bus_if.acc_clr = 1'b1;
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 16'd9, "acoin");
    chk("acoin.acc", 64'(bus_if.acc), 64'd9);
    bus_if.acc_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
